// File: rtl/ptp_rx_stamp_engine.sv
// Host-side PTP receive stage: filters framed packets from a show-ahead FIFO,
// stamps local/global receive time into PTP packets and keeps saturating statistics.
module ptp_rx_stamp_engine #(
    parameter int TS_W        = 19,
    parameter int GTS_W       = 48,
    parameter int LT_OFFSET   = 11,
    parameter int GT_OFFSET   = 60,
    parameter int RESP_OFFSET = 22,
    parameter int MAX_LEN     = 2047,
    parameter int UF_WAIT     = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic [1:0]       iv_cfg_finish,
    input  logic             i_stamp_en,
    input  logic [8:0]       iv_data,
    input  logic             i_data_empty,
    output logic             o_data_rd,
    input  logic [TS_W-1:0]  timer,
    input  logic [GTS_W-1:0] iv_syned_global_time,
    output logic [8:0]       ov_data,
    output logic             o_data_wr,
    output logic             o_underflow_pulse,
    output logic             o_oversize_pulse,
    output logic [2:0]       ov_state,
    input  logic             i_cnt_clr,
    output logic [CNT_W-1:0] ov_fwd_cnt,
    output logic [CNT_W-1:0] ov_disc_cnt,
    output logic [CNT_W-1:0] ov_err_cnt
);
    localparam int GTS_B = GTS_W / 8;
    // Index counter is wide enough that no configured offset aliases onto a smaller index.
    localparam int CW = $clog2(MAX_LEN + GT_OFFSET + LT_OFFSET + RESP_OFFSET + GTS_B + 4);
    localparam int WW = (UF_WAIT > 1) ? $clog2(UF_WAIT + 1) : 1;
    localparam logic [CW-1:0] LT_IDX   = CW'(LT_OFFSET);
    localparam logic [CW-1:0] LT_IDX1  = CW'(LT_OFFSET + 1);
    localparam logic [CW-1:0] LT_IDX2  = CW'(LT_OFFSET + 2);
    localparam logic [CW-1:0] GT_IDX   = CW'(GT_OFFSET);
    localparam logic [CW-1:0] RESP_IDX = CW'(RESP_OFFSET);
    localparam logic [CW-1:0] MAX_IDX  = CW'(MAX_LEN - 1);
    localparam logic [WW-1:0] UF_LAST  = WW'(UF_WAIT - 1);
    localparam logic [8:0]    ABORT_WORD = 9'h100;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TRANS = 3'd1,
        S_DISC  = 3'd2,
        S_STALL = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic              is_ptp_q, is_ptp_d;
    logic              resp_q, resp_d;
    logic [TS_W-1:0]   lts_q, lts_d;
    logic [GTS_W-1:0]  gts_q, gts_d;
    logic [8:0]        data_q, data_d;
    logic              wr_q, wr_d;
    logic              uf_q, uf_d;
    logic              os_q, os_d;
    logic              data_rd;
    logic              head_pass;
    logic              os_hit, uf_hit, resp_hit;
    logic [8:0]        stamp_word;
    logic [2:0]        inc;
    logic [3*CNT_W-1:0] stat_all;

    always_comb begin
        case (iv_cfg_finish)
            2'd0:    head_pass = 1'b0;
            2'd1:    head_pass = (iv_data[7:5] == 3'b101);
            2'd2:    head_pass = (iv_data[7:5] > 3'b010);
            default: head_pass = 1'b1;
        endcase
    end

    assign os_hit   = (cnt_q == MAX_IDX);
    assign resp_hit = (cnt_q == RESP_IDX) && (iv_data[3:0] == 4'd4);
    // A tolerance of one cycle aborts on the very first empty cycle in TRANS.
    assign uf_hit   = (state_q == S_TRANS) ? (UF_WAIT <= 1) : (wait_q == UF_LAST);

    always_comb begin
        stamp_word = iv_data;
        if (is_ptp_q && i_stamp_en) begin
            if (cnt_q == LT_IDX) begin
                stamp_word[TS_W-17:0] = lts_q[TS_W-1:16];
            end else if (cnt_q == LT_IDX1) begin
                stamp_word = {1'b0, lts_q[15:8]};
            end else if (cnt_q == LT_IDX2) begin
                stamp_word = {1'b0, lts_q[7:0]};
            end else if (!resp_q) begin
                for (int k = 0; k < GTS_B; k++) begin
                    if (cnt_q == GT_IDX + CW'(k)) begin
                        stamp_word = {1'b0, gts_q[GTS_W-1-8*k -: 8]};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wait_q   <= '0;
            is_ptp_q <= 1'b0;
            resp_q   <= 1'b0;
            lts_q    <= '0;
            gts_q    <= '0;
            data_q   <= '0;
            wr_q     <= 1'b0;
            uf_q     <= 1'b0;
            os_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            is_ptp_q <= is_ptp_d;
            resp_q   <= resp_d;
            lts_q    <= lts_d;
            gts_q    <= gts_d;
            data_q   <= data_d;
            wr_q     <= wr_d;
            uf_q     <= uf_d;
            os_q     <= os_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!i_data_empty && iv_data[8]) state_d = head_pass ? S_TRANS : S_DISC;
            end
            S_TRANS, S_STALL: begin
                if (!i_data_empty) begin
                    if (iv_data[8])  state_d = S_IDLE;
                    else if (os_hit) state_d = S_DRAIN;
                    else             state_d = S_TRANS;
                end else if (uf_hit) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_STALL;
                end
            end
            S_DISC, S_DRAIN: begin
                if (!i_data_empty && iv_data[8]) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_rd  = 1'b0;
        data_d   = data_q;
        wr_d     = 1'b0;
        uf_d     = 1'b0;
        os_d     = 1'b0;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        is_ptp_d = is_ptp_q;
        resp_d   = resp_q;
        lts_d    = lts_q;
        gts_d    = gts_q;
        inc      = '0;
        case (state_q)
            S_IDLE: begin
                if (!i_data_empty) begin
                    data_rd = 1'b1;
                    if (iv_data[8]) begin
                        lts_d = timer;
                        gts_d = iv_syned_global_time;
                        if (head_pass) begin
                            wr_d     = 1'b1;
                            data_d   = iv_data;
                            cnt_d    = CW'(1);
                            is_ptp_d = (iv_data[7:5] == 3'b100);
                            resp_d   = 1'b0;
                        end else begin
                            inc[1] = 1'b1;
                        end
                    end
                end
            end
            S_TRANS, S_STALL: begin
                if (!i_data_empty) begin
                    data_rd = 1'b1;
                    wr_d    = 1'b1;
                    wait_d  = '0;
                    if (resp_hit) resp_d = 1'b1;
                    if (iv_data[8]) begin
                        data_d = stamp_word;
                        inc[0] = 1'b1;
                    end else if (os_hit) begin
                        data_d = ABORT_WORD;
                        os_d   = 1'b1;
                        inc[2] = 1'b1;
                    end else begin
                        data_d = stamp_word;
                        cnt_d  = cnt_q + 1'b1;
                    end
                end else if (uf_hit) begin
                    wr_d   = 1'b1;
                    data_d = ABORT_WORD;
                    uf_d   = 1'b1;
                    inc[2] = 1'b1;
                end else if (state_q == S_TRANS) begin
                    wait_d = WW'(1);
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DISC, S_DRAIN: data_rd = !i_data_empty;
            default: ;
        endcase
    end

    // Statistics: index 0 forwarded, 1 discarded, 2 aborted; clear beats increment.
    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
        logic [CNT_W-1:0] stat_q, stat_d;
        always_comb begin
            stat_d = stat_q;
            if (i_cnt_clr)                       stat_d = '0;
            else if (inc[gi] && (stat_q != '1))  stat_d = stat_q + 1'b1;
        end
        always_ff @(posedge clk_sys) begin
            if (!reset_n) stat_q <= '0;
            else          stat_q <= stat_d;
        end
        assign stat_all[gi*CNT_W +: CNT_W] = stat_q;
    end

    assign o_data_rd         = data_rd;
    assign ov_data           = data_q;
    assign o_data_wr         = wr_q;
    assign o_underflow_pulse = uf_q;
    assign o_oversize_pulse  = os_q;
    assign ov_state          = state_q;
    assign ov_fwd_cnt        = stat_all[0*CNT_W +: CNT_W];
    assign ov_disc_cnt       = stat_all[1*CNT_W +: CNT_W];
    assign ov_err_cnt        = stat_all[2*CNT_W +: CNT_W];
endmodule

// File: doc/ptp_rx_stamp_engine.md
Name: ptp_rx_stamp_engine

Overview:
- Parametrised successor to the host-side PTP receive stage.
- Pops 9-bit framed words (bit8 = head/tail flag) from a show-ahead RX FIFO and filters packets by configuration/sync phase.
- Stamps local and global receive timestamps into PTP packets at parametrised byte offsets and forwards them to the host-RX pipeline.
- Adds beyond the previous generation: bounded underflow stall, oversize truncation, a stamping enable, and saturating statistics counters.

Parameters:
TS_W, 19, local timer width (17..24)
GTS_W, 48, global time width (multiple of 8, max 64)
LT_OFFSET, 11, word index of first local-TS byte (head = index 0)
GT_OFFSET, 60, word index of first global-TS byte
RESP_OFFSET, 22, word index whose low nibble identifies PTP response (value 4)
MAX_LEN, 2047, max words per packet incl. head and tail
UF_WAIT, 4, cycles of mid-packet FIFO empty tolerated before underflow error
CNT_W, 16, statistics counter width

Ports:
clk_sys  in  1  system clock
reset_n  in  1  synchronous active-low reset
iv_cfg_finish  in  2  0 drop all; 1 NMAC(101) only; 2 all except 000/001/010; 3 all
i_stamp_en  in  1  1 = stamp PTP packets, 0 = pass unmodified
iv_data  in  9  FIFO head word, valid when i_data_empty=0
i_data_empty  in  1  FIFO empty
o_data_rd  out  1  pop current word (combinational from state and inputs)
timer  in  TS_W  local free-running timer
iv_syned_global_time  in  GTS_W  synchronised global time
ov_data  out  9  output word
o_data_wr  out  1  output word valid
o_underflow_pulse  out  1  one-cycle pulse on underflow abort
o_oversize_pulse  out  1  one-cycle pulse on oversize abort
ov_state  out  3  current FSM state
i_cnt_clr  in  1  synchronous clear of all counters
ov_fwd_cnt / ov_disc_cnt / ov_err_cnt  out  CNT_W each  forwarded / filtered / aborted packets, saturating

Behaviour:
- Reset (reset_n=0 at clk edge): ov_data=0, o_data_wr=0, pulses=0, counters=0, state IDLE. Reset mid-packet abandons it; no tail is emitted.
- Output latency: ov_data/o_data_wr registered, 1 cycle after the pop.
- States: IDLE(0), TRANS(1), DISC(2), STALL(3), DRAIN(4).
- IDLE:
  - iv_data[8]=1 and !empty: pop the head and sample timer and global time into ts registers.
  - Head type iv_data[7:5] passes the filter: forward head, word count=1, is_ptp=(type==100), state TRANS.
  - Head type fails the filter: pop, no write, disc_cnt++, state DISC.
  - !empty but bit8=0 (orphan word): pop and drop, stay IDLE.
- TRANS, !empty: pop and write, count++.
  - Word index i = count before increment.
  - Stamping applies only when is_ptp and i_stamp_en.
  - i==LT_OFFSET: output {iv_data[8:TS_W-16], ts[TS_W-1:16]}. The low (TS_W-16) bits are replaced; bit8 is preserved.
  - i==LT_OFFSET+1 and LT_OFFSET+2: {0, ts[15:8]}, {0, ts[7:0]}.
  - i==RESP_OFFSET and iv_data[3:0]==4: set resp flag, effective for i>RESP_OFFSET.
  - GT_OFFSET..GT_OFFSET+GTS_W/8-1, only when resp flag clear: global-TS bytes, MSB first, bit8=0.
  - bit8=1 at i>0 (tail): write the word, fwd_cnt++, state IDLE.
- TRANS, empty: state STALL, wait counter=1, no write.
- STALL:
  - !empty: resume TRANS behaviour in that same cycle.
  - Wait counter reaches UF_WAIT: write {1,8'h00}, pulse o_underflow_pulse, err_cnt++, state DRAIN.
- Oversize: if i==MAX_LEN-1 and the word is not a tail, write {1,8'h00} instead of the word (still popped), pulse o_oversize_pulse, err_cnt++, state DRAIN.
- DISC/DRAIN: pop while !empty, no writes. Popping a bit8=1 word returns to IDLE. Empty is a plain stall, never an error.
- cfg change mid-packet: takes effect at the next head only.
- Counters: saturate at all-ones. If i_cnt_clr coincides with an increment, the clear wins.
- Timestamps must not change during a packet.

Test Plan:
- cfg=3, stamp_en=1, 80-word PTP sync, type 100, word22 low nibble 0, timer=19'h5_A5A5, gtime=48'h0102_0304_0506 -> word11 low 3 bits=3'b101, words 12/13=A5/A5, words 60-65=01..06, fwd_cnt=1.
- Same packet with word22=8'h04 -> local TS stamped; words 60-65 pass unchanged.
- cfg=1: NMAC (101) packet then PTP packet -> NMAC forwarded unchanged, PTP not written, disc_cnt=1, next head in IDLE handled normally.
- FIFO empty 3 cycles mid-packet (UF_WAIT=4) -> output resumes with no gap words and no pulse. Empty 4 cycles -> {1,00} written, o_underflow_pulse one cycle, err_cnt=1, remainder drained to its tail.
- MAX_LEN=64, 100-word packet -> 63 words plus forced tail {1,00} at index 63, o_oversize_pulse, 36 words drained, next packet forwarded correctly.
- reset_n=0 at word 30 of a packet -> next cycle all outputs 0, state IDLE. Counters at all-ones plus increment stay saturated. i_cnt_clr together with an increment gives 0.
